// File: rtl/snapshot_pkg.sv
// Shared types and helpers for the axis_snapshot stream capture block.
package snapshot_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Address width for a buffer of the given depth (at least one bit).
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port buffer: one write port, one registered read port, one clock.
module sdp_ram
  import snapshot_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32
) (
  input  logic                      clk,
  input  logic                      i_wr_en,
  input  logic [addr_w(DEPTH)-1:0]  i_wr_addr,
  input  logic [WIDTH-1:0]          i_wr_data,
  input  logic                      i_rd_en,
  input  logic [addr_w(DEPTH)-1:0]  i_rd_addr,
  output logic [WIDTH-1:0]          o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read data only advances on a read enable, so it holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/axis_snapshot.sv
// Arms on a pulse, captures DEPTH accepted beats of a monitored AXIS stream, replays them on m_axis.
// Define SNAPSHOT_FRAME_ALIGN_EN to hold ARMED until a frame boundary (accepted tlast beat).
module axis_snapshot
  import snapshot_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tready,
  input  logic [2*WIDTH-1:0]   s_axis_tdata,
  input  logic                 s_axis_tlast,
  output logic                 m_axis_tvalid,
  output logic [2*WIDTH-1:0]   m_axis_tdata,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic [STATE_W-1:0]   state,
  output logic                 overflow
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned AW = addr_w(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [AW-1:0]   r_wr_addr;
  logic [AW-1:0]   r_rd_addr;
  logic            r_rd_all;
  logic            r_tvalid;
  logic            r_tlast;
  logic            r_overflow;
  logic            w_beat;
  logic            w_last_hs;
  logic            w_wr_en;
  logic            w_rd_en;
  logic            w_ovf_set;
  logic            w_frame_start;
  logic [DW-1:0]   w_rd_data;

  assign w_beat    = s_axis_tvalid && s_axis_tready;
  assign w_last_hs = r_tvalid && r_tlast && m_axis_tready;

`ifdef SNAPSHOT_FRAME_ALIGN_EN
  assign w_frame_start = w_beat && s_axis_tlast;
`else
  logic w_unused_tlast;
  assign w_unused_tlast = s_axis_tlast;
  assign w_frame_start  = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (arm) w_state_nxt = ARMED;
      ARMED:   if (w_frame_start) w_state_nxt = CAPTURE;
      CAPTURE: if (w_beat && (r_wr_addr == LAST_ADDR)) w_state_nxt = DONE;
      DONE:    if (w_last_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Per-state control strobes
  always_comb begin
    w_wr_en   = 1'b0;
    w_rd_en   = 1'b0;
    w_ovf_set = 1'b0;
    case (r_state)
      CAPTURE: w_wr_en = w_beat;
      DONE: begin
        w_rd_en   = !r_rd_all && (!r_tvalid || m_axis_tready);
        w_ovf_set = w_beat;
      end
      default: ;
    endcase
  end

  // Address counters and readback output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      r_rd_all   <= 1'b0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        r_wr_addr <= '0;
        r_rd_addr <= '0;
        r_rd_all  <= 1'b0;
        if (arm) r_overflow <= 1'b0;
      end
      if (w_wr_en && (r_wr_addr != LAST_ADDR)) begin
        r_wr_addr <= r_wr_addr + AW'(1);
      end
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end
      // A read issued now lands in the RAM output register together with tvalid.
      if (w_rd_en) begin
        r_tvalid <= 1'b1;
        r_tlast  <= (r_rd_addr == LAST_ADDR);
        if (r_rd_addr == LAST_ADDR) begin
          r_rd_all <= 1'b1;
        end else begin
          r_rd_addr <= r_rd_addr + AW'(1);
        end
      end else if (r_tvalid && m_axis_tready) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
    end
  end

  sdp_ram #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_addr),
    .i_wr_data (s_axis_tdata),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = w_rd_data;
  assign m_axis_tlast  = r_tlast;
  assign state         = r_state;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_axis_snapshot.sv
// Randomized bench for axis_snapshot against a queue-based behavioural model.
module tb_axis_snapshot;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned DW    = 2 * WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready = 1'b0;
  logic [DW-1:0] s_axis_tdata  = '0;
  logic          s_axis_tlast  = 1'b0;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b0;
  logic [1:0]    state;
  logic          overflow;

  int errors = 0;
  int checks = 0;

  axis_snapshot #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .arm           (arm),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .state         (state),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Stimulus modes: vmode 0=always valid, 1=valid 1-in-3, 2=random; mmode 0=ready, 1=random, 2=stalled
  int   vmode   = 0;
  int   mmode   = 0;
  int   ramp    = 0;
  bit   arm_req = 1'b0;
  int   arm_data = 0;

  // Model: captured words, read index, sticky overflow, abstract phase 0..3
  int            m_state = 0;
  logic [DW-1:0] m_cap[$];
  int            m_rd = 0;
  bit            m_ovf = 1'b0;
  int            snaps_done = 0;
  logic [DW-1:0] got[$];

  // Input driver: ramp data changes just after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ramp++;
      s_axis_tdata = DW'(ramp);
      s_axis_tlast = (ramp % 8 == 7);
      case (vmode)
        0: begin s_axis_tvalid = 1'b1; s_axis_tready = 1'b1; end
        1: begin s_axis_tvalid = (ramp % 3 == 0); s_axis_tready = 1'b1; end
        default: begin
          s_axis_tvalid = 1'($urandom_range(0, 1));
          s_axis_tready = ($urandom_range(0, 3) != 0);
        end
      endcase
      case (mmode)
        0: m_axis_tready = 1'b1;
        1: m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b0;
      endcase
      arm = arm_req;
      if (arm_req) begin
        arm_data = ramp;
        arm_req  = 1'b0;
      end
    end
  end

  // Compare process: check outputs at the falling edge, then predict the next cycle
  initial begin
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;
    int            done_wait  = 0;
    bit            seen_valid = 1'b0;
    bit            beat;
    bit            hs;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_state = 0;
        m_cap.delete();
        m_rd = 0;
        m_ovf = 1'b0;
        prev_stall = 1'b0;
      end
      check("state", 64'(state), 64'(m_state));
      check("overflow", 64'(overflow), 64'(m_ovf));
      if (m_state != 3) begin
        check("tvalid_low", 64'(m_axis_tvalid), 64'd0);
      end else if (!seen_valid) begin
        if (m_axis_tvalid || done_wait == 2) begin
          check("tvalid_within_2", 64'(m_axis_tvalid), 64'd1);
          seen_valid = 1'b1;
        end else begin
          done_wait++;
        end
      end
      if (prev_stall) begin
        check("hold_valid", 64'(m_axis_tvalid), 64'd1);
        check("hold_data", 64'(m_axis_tdata), 64'(prev_data));
        check("hold_last", 64'(m_axis_tlast), 64'(prev_last));
      end
      prev_stall = m_axis_tvalid && !m_axis_tready && rst;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      if (rst) begin
        beat = s_axis_tvalid && s_axis_tready;
        hs   = m_axis_tvalid && m_axis_tready;
        case (m_state)
          0: if (arm) begin
            m_state = 1;
            m_ovf = 1'b0;
            m_cap.delete();
            m_rd = 0;
          end
          1: begin
`ifdef SNAPSHOT_FRAME_ALIGN_EN
            if (beat && s_axis_tlast) m_state = 2;
`else
            m_state = 2;
`endif
          end
          2: if (beat) begin
            m_cap.push_back(s_axis_tdata);
            if (m_cap.size() == DEPTH) begin
              m_state = 3;
              done_wait = 0;
              seen_valid = 1'b0;
            end
          end
          default: begin
            if (beat) m_ovf = 1'b1;
            if (hs) begin
              check("rd_data", 64'(m_axis_tdata), 64'(m_cap[m_rd]));
              check("rd_last", 64'(m_axis_tlast), 64'(m_rd == DEPTH - 1));
              got.push_back(m_axis_tdata);
              if (m_rd == DEPTH - 1) begin
                m_state = 0;
                snaps_done++;
              end
              m_rd++;
            end
          end
        endcase
      end
    end
  end

  task automatic start_arm();
    @(negedge clk);
    #1 arm_req = 1'b1;
  endtask

  task automatic wait_done(input int start, input int budget, input string tag);
    int n = 0;
    while (snaps_done == start && n < budget) begin
      @(posedge clk);
      n++;
    end
    #2;
    check({tag, "_complete"}, 64'(snaps_done - start), 64'd1);
    check({tag, "_count"}, 64'(got.size()), 64'(DEPTH));
  endtask

  task automatic run_snap(input int budget, input string tag);
    int st = snaps_done;
    got.delete();
    start_arm();
    wait_done(st, budget, tag);
  endtask

  // Hand-derived position of word 0 relative to the arm pulse
  task automatic check_word0(input string tag);
    if (got.size() == DEPTH) begin
`ifdef SNAPSHOT_FRAME_ALIGN_EN
      check({tag, "_frame_idx0"}, 64'(got[0] % 8), 64'd0);
`else
      check({tag, "_word0"}, 64'(got[0]), 64'(arm_data + 2));
      check({tag, "_word31"}, 64'(got[DEPTH-1]), 64'(arm_data + 33));
`endif
    end
  endtask

  initial begin
    int bad;
    int st;
    int n;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #1;
    check("reset_state", 64'(state), 64'd0);
    check("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);

    // Ramp, continuous valid, armed mid-frame
    vmode = 0; mmode = 0;
    while (ramp % 8 != 2) @(negedge clk);
    run_snap(400, "ramp");
    check_word0("ramp");

    // Valid 1-in-3: consecutive accepted beats are 3 apart in the ramp
    vmode = 1;
    run_snap(1500, "gap");
    if (got.size() == DEPTH) begin
      bad = 0;
      for (int i = 0; i < DEPTH - 1; i++) if (got[i+1] != got[i] + 3) bad++;
      check("gap_steps", 64'(bad), 64'd0);
    end

    // Random input and random readback backpressure
    for (int k = 0; k < 3; k++) begin
      vmode = 2; mmode = 1;
      run_snap(3000, "rand");
      if (got.size() == DEPTH) begin
        bad = 0;
        for (int i = 0; i < DEPTH - 1; i++) if (got[i+1] <= got[i]) bad++;
        check("rand_order", 64'(bad), 64'd0);
      end
    end

    // Overflow while readback is stalled, cleared by the next arm
    vmode = 0; mmode = 2;
    got.delete();
    st = snaps_done;
    start_arm();
    n = 0;
    while (m_state != 3 && n < 400) begin @(posedge clk); n++; end
    repeat (4) @(posedge clk);
    #2;
    check("ovf_set", 64'(overflow), 64'd1);
    check("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
    mmode = 0;
    wait_done(st, 400, "ovf");
    check("ovf_sticky", 64'(overflow), 64'd1);
    got.delete();
    st = snaps_done;
    start_arm();
    @(posedge clk);
    @(posedge clk);
    #2;
    check("ovf_cleared", 64'(overflow), 64'd0);
    check("armed_state", 64'(state), 64'd1);
    wait_done(st, 400, "ovf2");

    // Reset at word 10 of capture, then a clean snapshot
    vmode = 0; mmode = 0;
    got.delete();
    start_arm();
    n = 0;
    while (!(m_state == 2 && m_cap.size() == 10) && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("rst_at_word10", 64'(m_cap.size()), 64'd10);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_state", 64'(state), 64'd0);
    check("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    run_snap(400, "post_rst");
    check_word0("post_rst");

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_snapshot.md
AXIS_SNAPSHOT -- requirements
Module: axis_snapshot

Interface
REQ-001 SHALL have parameter WIDTH, default 16: bits per real/imag component; data word is 2*WIDTH.
REQ-002 SHALL have parameter DEPTH, default 32: number of words captured per snapshot; power of two, 2..4096.
REQ-003 SHALL have port clk, input, 1: sole clock, all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port arm, input, 1: single-cycle pulse that starts a snapshot.
REQ-006 SHALL have port s_axis_tvalid/tready/tdata/tlast, input, 1/1/2*WIDTH/1: monitored stream; block never drives tready.
REQ-007 SHALL have port m_axis_tvalid/tdata/tlast, output, 1/2*WIDTH/1, and m_axis_tready, input, 1: readback stream.
REQ-008 SHALL have port state, output, 2: current FSM state encoding.
REQ-009 SHALL have port overflow, output, 1: sticky; a valid beat arrived while DONE and unread.

Function
REQ-010 SHALL count input beat accepted only when s_axis_tvalid && s_axis_tready are both high in the same cycle.
REQ-011 SHALL implement FSM IDLE(0) -> ARMED(1) -> CAPTURE(2) -> DONE(3) -> IDLE.
REQ-012 SHALL move IDLE->ARMED on arm; arm in any other state is ignored.
REQ-013 SHALL move ARMED->CAPTURE on the next cycle, unless the frame-align option is compiled in (REQ-024).
REQ-014 SHALL, in CAPTURE, write each accepted beat to buffer[wr_addr], wr_addr incrementing from 0, with no gaps or duplicates.
REQ-015 SHALL move CAPTURE->DONE in the cycle the DEPTH-th beat is written; further beats are not stored.
REQ-016 SHALL, in DONE, present buffer words 0..DEPTH-1 in order on m_axis; m_axis_tvalid rises at most 2 cycles after entering DONE.
REQ-017 SHALL hold m_axis_tdata/tlast stable while m_axis_tvalid && !m_axis_tready (AXIS rule).
REQ-018 SHALL assert m_axis_tlast with word DEPTH-1 only, then return to IDLE on that handshake.
REQ-019 SHALL keep m_axis_tvalid low in IDLE, ARMED, and CAPTURE.
REQ-020 SHALL set overflow when an accepted beat occurs in DONE; cleared only by reset or arm.
REQ-021 SHALL accept write and read in one buffer (single clock, 1 write port, 1 read port, registered read); wr/rd addresses are $clog2(DEPTH) bits and never wrap inside a snapshot.

Reset
REQ-022 SHALL on rst low, immediately set state=IDLE, wr_addr=0, rd_addr=0, m_axis_tvalid=0, m_axis_tlast=0, overflow=0; buffer contents are undefined.
REQ-023 SHALL abandon any snapshot or readback in progress on reset mid-operation; no partial output after rst release.

Configuration
REQ-024 SHALL, with macro SNAPSHOT_FRAME_ALIGN_EN defined, stay in ARMED until an accepted beat with tlast=1, entering CAPTURE on the following cycle so word 0 is the first beat of a frame.
REQ-025 SHALL, without SNAPSHOT_FRAME_ALIGN_EN, ignore s_axis_tlast entirely; ARMED lasts exactly one cycle.

Structure
REQ-026 SHALL place the state enum (IDLE/ARMED/CAPTURE/DONE) and the state-width constant in shared package snapshot_pkg.
REQ-027 SHALL use one sub-module, sdp_ram (simple dual-port, registered read, parameters WIDTH and DEPTH), for the buffer.

Verification
REQ-028 SHALL cover: ramp tdata=0,1,2... every cycle, tready=1, arm -> m_axis yields 0..31 (one per arm latency offset) with tlast on word 31.
REQ-029 SHALL cover: s_axis_tvalid gapped 1-in-3 during CAPTURE -> readback holds exactly 32 consecutive accepted values, no duplicates.
REQ-030 SHALL cover: m_axis_tready toggled randomly -> data stable under backpressure, sequence unchanged, return to IDLE after tlast.
REQ-031 SHALL cover: input beats with m_axis stalled in DONE -> overflow=1; next arm clears it.
REQ-032 SHALL cover: rst pulled low at word 10 of CAPTURE -> state=0, m_axis_tvalid=0 next cycle; new arm yields a clean full snapshot.
REQ-033 SHALL cover, with SNAPSHOT_FRAME_ALIGN_EN: frames of 8 with tlast on index 7, arm mid-frame -> word 0 equals frame index 0.
